memory_arbiter_rr: RTL and testbench

- Parametrised successor to the fixed 4-state cache/scratchpad memory arbiter.
- Arbitrates NUM_REQ requesters (icache, dcache, scratchpad load/store ports, future DMA) onto one RAM port.
- Grant selection: fixed priority for a configurable subset of requesters, round-robin among the rest.
- Adds multi-beat bursts with auto-incrementing address and per-requester completion pulses.

---
 rtl/memory_arbiter_rr_pkg.sv | 26 ++
 rtl/memory_arbiter_rr_picker.sv | 33 +++
 rtl/memory_arbiter_rr.sv | 105 ++++++++++
 tb/tb_memory_arbiter_rr.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_rr_pkg.sv
// memory_arbiter_rr_pkg: shared types and the round-robin pick helper for the memory arbiter
//   ramstate_t  : RAM handshake state (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t : arbiter FSM state (IDLE, XFER)
//   pick_t      : result of rr_pick (valid flag + winning index)
package memory_arbiter_rr_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic {IDLE, XFER} arb_state_t;
    localparam int MAX_REQ = 8;
    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;
    // First active requester at or above ptr, wrapping modulo n.
    // The loop runs downward so the smallest offset from ptr is the last assignment.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr, input int n);
        pick_t p;
        p = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n && req[(int'(ptr) + k) % n]) begin
                p.valid = 1'b1;
                p.idx   = 3'((int'(ptr) + k) % n);
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// rr_priority_picker: combinational grant selection, fixed priority first, round-robin for the rest
//   i_req   : per-requester active flags
//   i_ptr   : round-robin start index
//   o_valid : some requester is active
//   o_idx   : winning requester index
//   o_prio  : winner came from the priority subset
module rr_priority_picker
    import memory_arbiter_rr_pkg::*;
#(
    parameter int                 NUM_REQ   = 4,
    parameter logic [NUM_REQ-1:0] PRIO_MASK = NUM_REQ'(1)
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic                       o_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_prio
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] w_prio_req;
    logic [IW-1:0]      w_prio_idx;
    pick_t              w_rr;
    assign w_prio_req = i_req & PRIO_MASK;
    always_comb begin
        w_prio_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (w_prio_req[i]) w_prio_idx = IW'(i);
    end
    assign w_rr    = rr_pick(MAX_REQ'(i_req), 3'(i_ptr), NUM_REQ);
    assign o_prio  = |w_prio_req;
    assign o_valid = o_prio | w_rr.valid;
    assign o_idx   = o_prio ? w_prio_idx : IW'(w_rr.idx);
endmodule

// File: rtl/memory_arbiter_rr.sv
// memory_arbiter_rr: NUM_REQ-way RAM arbiter with priority/round-robin grants and multi-beat bursts
//   i_clk, i_nrst        : clock, asynchronous active-low reset
//   i_req_ren/i_req_wen  : per-requester read/write requests (write wins)
//   i_req_addr/_wdata/_len : packed per-requester start address, beat data, burst length-1
//   o_req_wait/_beat/_done : per-requester wait, beat-complete pulse, burst-complete pulse
//   o_req_rdata          : read data, valid with o_req_beat
//   o_ram_ren/_wen/_addr/_store, i_ram_load, i_ram_state : RAM port
module memory_arbiter_rr
    import memory_arbiter_rr_pkg::*;
#(
    parameter int                 NUM_REQ   = 4,
    parameter int                 AW        = 32,
    parameter int                 DW        = 32,
    parameter int                 LENW      = 3,
    parameter logic [NUM_REQ-1:0] PRIO_MASK = NUM_REQ'(1),
    parameter int                 ADDR_STEP = 4
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    input  logic [NUM_REQ-1:0]      i_req_ren,
    input  logic [NUM_REQ-1:0]      i_req_wen,
    input  logic [NUM_REQ*AW-1:0]   i_req_addr,
    input  logic [NUM_REQ*DW-1:0]   i_req_wdata,
    input  logic [NUM_REQ*LENW-1:0] i_req_len,
    output logic [NUM_REQ-1:0]      o_req_wait,
    output logic [NUM_REQ-1:0]      o_req_beat,
    output logic [NUM_REQ-1:0]      o_req_done,
    output logic [DW-1:0]           o_req_rdata,
    output logic                    o_ram_ren,
    output logic                    o_ram_wen,
    output logic [AW-1:0]           o_ram_addr,
    output logic [DW-1:0]           o_ram_store,
    input  logic [DW-1:0]           i_ram_load,
    input  logic [1:0]              i_ram_state
);
    localparam int IW = $clog2(NUM_REQ);
    arb_state_t         r_state, w_next;
    logic [IW-1:0]      r_grant, r_ptr, w_pick_idx;
    logic               r_is_write, r_prio, w_pick_valid, w_pick_prio;
    logic [AW-1:0]      r_base;
    logic [LENW-1:0]    r_len, r_beat_cnt;
    logic [NUM_REQ-1:0] w_req, w_onehot;
    logic               w_xfer, w_abort, w_beat, w_last, w_start;

    rr_priority_picker #(.NUM_REQ(NUM_REQ), .PRIO_MASK(PRIO_MASK)) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx),
        .o_prio  (w_pick_prio)
    );

    assign w_req    = i_req_ren | i_req_wen;
    assign w_xfer   = r_state == XFER;
    assign w_start  = !w_xfer && w_pick_valid;
    // Granted requester withdrew: drop the RAM enables this very cycle.
    assign w_abort  = w_xfer && !w_req[r_grant];
    assign w_beat   = w_xfer && !w_abort && ramstate_t'(i_ram_state) == ACCESS;
    assign w_last   = w_beat && r_beat_cnt == r_len;
    assign w_onehot = NUM_REQ'(1) << r_grant;

    always_comb begin
        w_next = w_xfer ? ((w_abort || w_last) ? IDLE : XFER) : (w_pick_valid ? XFER : IDLE);
    end

    assign o_ram_ren   = w_xfer && !w_abort && !r_is_write;
    assign o_ram_wen   = w_xfer && !w_abort && r_is_write;
    assign o_ram_addr  = w_xfer ? r_base + AW'(r_beat_cnt) * AW'(ADDR_STEP) : '0;
    assign o_ram_store = w_xfer ? i_req_wdata[r_grant*DW +: DW] : '0;
    assign o_req_wait  = w_beat ? ~w_onehot : '1;
    assign o_req_beat  = w_beat ? w_onehot : '0;
    assign o_req_done  = w_last ? w_onehot : '0;
    assign o_req_rdata = (w_beat && !r_is_write) ? i_ram_load : '0;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_grant    <= '0;
            r_ptr      <= '0;
            r_is_write <= 1'b0;
            r_prio     <= 1'b0;
            r_base     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_start) begin
                r_grant    <= w_pick_idx;
                r_is_write <= i_req_wen[w_pick_idx];
                r_base     <= i_req_addr[w_pick_idx*AW +: AW];
                r_len      <= i_req_len[w_pick_idx*LENW +: LENW];
                r_prio     <= w_pick_prio;
                r_beat_cnt <= '0;
            end else if (w_beat && !w_last) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            // Only round-robin grants advance the pointer; priority grants leave it alone.
            if ((w_abort || w_last) && !r_prio)
                r_ptr <= (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
        end
    end
endmodule

// File: tb/tb_memory_arbiter_rr.sv
// tb_memory_arbiter_rr: randomized bench against a transaction-level model of the arbiter
module tb_memory_arbiter_rr;
    import memory_arbiter_rr_pkg::*;
    localparam int N = 4, AW = 32, DW = 32, LW = 3, STEP = 4;
    localparam logic [N-1:0] PM = 4'b0001;

    logic clk = 1'b0, nrst = 1'b0;
    logic [N-1:0] ren, wen, wait_o, beat_o, done_o;
    logic [N*AW-1:0] addr_bus;
    logic [N*DW-1:0] wdata_bus;
    logic [N*LW-1:0] len_bus;
    logic [DW-1:0] rdata_o, ram_store, ram_load;
    logic [AW-1:0] ram_addr;
    logic ram_ren, ram_wen;
    logic [1:0] ram_state;

    always #5 clk = ~clk;

    memory_arbiter_rr #(.NUM_REQ(N), .AW(AW), .DW(DW), .LENW(LW), .PRIO_MASK(PM), .ADDR_STEP(STEP)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_req_ren(ren), .i_req_wen(wen),
        .i_req_addr(addr_bus), .i_req_wdata(wdata_bus), .i_req_len(len_bus),
        .o_req_wait(wait_o), .o_req_beat(beat_o), .o_req_done(done_o), .o_req_rdata(rdata_o),
        .o_ram_ren(ram_ren), .o_ram_wen(ram_wen), .o_ram_addr(ram_addr), .o_ram_store(ram_store),
        .i_ram_load(ram_load), .i_ram_state(ram_state)
    );

    bit          act[N], drop_req[N];
    int          mode[N];
    logic [AW-1:0] a[N];
    logic [LW-1:0] l[N];
    logic [DW-1:0] wd[N];
    logic [N-1:0] pm;

    bit          m_busy, m_wr, m_prio;
    int          m_ch, m_left, m_ptr, n_rst;
    logic [AW-1:0] m_addr;
    int          n_chk, n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    task automatic pack();
        for (int c = 0; c < N; c++) begin
            ren[c] = act[c] && mode[c] != 1;
            wen[c] = act[c] && mode[c] != 0;
            addr_bus[c*AW +: AW]  = a[c];
            len_bus[c*LW +: LW]   = l[c];
            wdata_bus[c*DW +: DW] = wd[c];
        end
    endtask

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            if (act[c]) begin
                if (drop_req[c] || $urandom_range(39) == 0) act[c] = 0;
                else if ($urandom_range(19) == 0) mode[c] = $urandom_range(2);
            end else if ($urandom_range(3) == 0) begin
                act[c]  = 1;
                mode[c] = $urandom_range(2);
                a[c]    = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 : $urandom;
                l[c]    = LW'($urandom_range(7));
            end
            drop_req[c] = 0;
            wd[c] = $urandom;
        end
        pack();
        ram_state = $urandom_range(1) ? 2'd2 : 2'($urandom_range(3));
        ram_load  = $urandom;
    endtask

    // Expected outputs for the current cycle from the arbitration rules, then advance the model.
    task automatic check_cycle();
        logic [N-1:0] e_wait, e_beat, e_done;
        logic e_ren, e_wen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_store, e_rdata;
        int g;
        bit pr;
        e_wait = '1; e_beat = '0; e_done = '0; e_ren = 0; e_wen = 0;
        e_addr = '0; e_store = '0; e_rdata = '0;
        if (!m_busy) begin
            g = -1; pr = 0;
            for (int c = 0; c < N; c++)
                if (g < 0 && pm[c] && (ren[c] | wen[c])) begin g = c; pr = 1; end
            for (int k = 0; k < N; k++)
                if (g < 0 && (ren[(m_ptr + k) % N] | wen[(m_ptr + k) % N])) g = (m_ptr + k) % N;
            if (g >= 0) begin
                m_busy = 1; m_ch = g; m_prio = pr; m_wr = wen[g];
                m_left = int'(l[g]) + 1; m_addr = a[g];
            end
        end else begin
            e_addr  = m_addr;
            e_store = wd[m_ch];
            if (!(ren[m_ch] | wen[m_ch])) begin
                m_busy = 0;
                if (!m_prio) m_ptr = (m_ch + 1) % N;
            end else begin
                e_ren = !m_wr; e_wen = m_wr;
                if (ram_state == 2'(ACCESS)) begin
                    e_wait[m_ch] = 0; e_beat[m_ch] = 1;
                    e_rdata = m_wr ? '0 : ram_load;
                    m_left--; m_addr += STEP;
                    if (m_left == 0) begin
                        e_done[m_ch] = 1; m_busy = 0;
                        drop_req[m_ch] = 1'($urandom_range(1));
                        if (!m_prio) m_ptr = (m_ch + 1) % N;
                    end
                end
            end
        end
        chk("ram_en",  {ram_ren, ram_wen}, {e_ren, e_wen});
        chk("ramaddr", ram_addr, e_addr);
        chk("ramstore", ram_store, e_store);
        chk("wait",  wait_o, e_wait);
        chk("beat",  beat_o, e_beat);
        chk("done",  done_o, e_done);
        chk("rdata", rdata_o, e_rdata);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"},    {ram_ren, ram_wen}, 2'b00);
        chk({tag, "_addr"},  ram_addr, '0);
        chk({tag, "_store"}, ram_store, '0);
        chk({tag, "_wait"},  wait_o, {N{1'b1}});
        chk({tag, "_beat"},  {beat_o, done_o}, '0);
        chk({tag, "_rdata"}, rdata_o, '0);
    endtask

    initial begin
        pm = PM;
        for (int c = 0; c < N; c++) begin act[c] = 0; mode[c] = 0; a[c] = '0; l[c] = '0; wd[c] = '0; drop_req[c] = 0; end
        pack();
        ram_state = 2'd0; ram_load = '0;
        m_busy = 0; m_ptr = 0; n_rst = 0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            drive();
            @(negedge clk);
            check_cycle();
            if (i >= 1000 * (n_rst + 1) && m_busy && n_rst < 3) begin
                #2 nrst = 1'b0;
                #1 check_reset_outputs("midrst");
                for (int c = 0; c < N; c++) act[c] = 0;
                pack();
                m_busy = 0; m_ptr = 0;
                n_rst++;
                @(posedge clk); #1 nrst = 1'b1;
            end
        end
        chk("mid_burst_resets", 64'(n_rst), 64'd3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
